// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus: access sizes, initiator states,
// and the byte-enable / alignment helpers used by every bus master.
package bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } init_state_e;

  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // Only the two low address bits decide alignment; size 3 is never legal.
  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return (addr_lo[0] == 1'b0);
      SIZE_WORD: return (addr_lo == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Right-aligned load data extension (byte/half/word, signed or unsigned).
// Purely combinational so it can be shared with other bus masters.
module load_extender
  import bus_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = i_raw[7]  & ~i_unsigned;
  assign w_sign_h = i_raw[15] & ~i_unsigned;

  always_comb begin
    o_data = i_raw;
    case (i_size)
      SIZE_BYTE: o_data = {{24{w_sign_b}}, i_raw[7:0]};
      SIZE_HALF: o_data = {{16{w_sign_h}}, i_raw[15:0]};
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/bus_initiator.sv
// Peripheral bus master: turns a single valid/ready load/store request into a
// drive / wait-fc / release / wait-fc-low bus cycle with a one-cycle response.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  init_state_e       r_state;
  logic [31:0]       r_addr;
  logic [3:0]        r_mask;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic [31:0]       r_wdata;
  logic [31:0]       r_raw;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;

  logic              w_accept;
  logic              w_legal;
  logic [31:0]       w_ext;

  assign w_legal  = is_aligned(req_addr[1:0], req_size);
  assign w_accept = (r_state == ST_IDLE) && req_valid && w_legal;

  load_extender u_ext (
    .i_raw      (r_raw),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  // Strobes and data drive decode straight from state so reset kills them at once.
  assign req_ready     = (r_state == ST_IDLE);
  assign rd_bus        = (r_state == ST_ACCESS) && !r_we;
  assign wr_bus        = (r_state == ST_ACCESS) &&  r_we;
  assign data_bus      = wr_bus ? r_wdata : 'z;
  assign addr_bus      = r_addr;
  assign data_mask_bus = r_mask;
  assign resp_valid    = r_resp_valid;
  assign resp_err      = r_resp_err;
  assign resp_rdata    = r_resp_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && !w_legal) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else if (w_accept) begin
            r_addr  <= req_addr;
            r_mask  <= size_to_mask(req_size);
            r_cnt   <= '0;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (fc_bus) begin
            r_err   <= 1'b0;
            r_state <= ST_RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          // Address and mask stay put until the responder drops fc.
          if (!fc_bus) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_err;
            r_resp_rdata <= (r_err || r_we) ? 32'd0 : w_ext;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Request payload and captured read data need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we       <= req_we;
      r_wdata    <= req_wdata;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
    end
    if ((r_state == ST_ACCESS) && fc_bus && !r_we) begin
      r_raw <= data_bus;
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a configurable responder model.
module tb_bus_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  logic        fc_bus;

  // Responder: 0 = absent, 1 = combinational fc, 2 = registered fc.
  int          mode;
  logic        fc_r;
  logic [31:0] rsp_data;
  logic        force_drv;
  logic [31:0] force_val;
  logic        tb_drv;
  logic [31:0] tb_data;

  int n_tests;
  int n_fail;

  bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .addr_bus      (addr_bus),
    .data_bus      (data_bus),
    .rd_bus        (rd_bus),
    .wr_bus        (wr_bus),
    .data_mask_bus (data_mask_bus),
    .fc_bus        (fc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) fc_r <= (mode == 2) && (rd_bus || wr_bus);

  always_comb begin
    fc_bus = 1'b0;
    if (mode == 1) fc_bus = rd_bus || wr_bus;
    else if (mode == 2) fc_bus = fc_r;
  end

  assign tb_drv   = force_drv || ((mode != 0) && rd_bus);
  assign tb_data  = force_drv ? force_val : rsp_data;
  assign data_bus = tb_drv ? tb_data : 32'bz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at the current cycle and follow it to resp_valid.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [31:0] bus_rd,
                         output int lat, output int rd_cnt, output int wr_cnt,
                         output logic [3:0] mask_seen, output logic [31:0] addr_seen,
                         output logic [31:0] wdata_seen);
    rsp_data     = bus_rd;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_valid    = 1'b1;
    lat = 0; rd_cnt = 0; wr_cnt = 0;
    mask_seen = '0; addr_seen = '0; wdata_seen = '0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      req_valid = 1'b0;
      if (rd_bus) rd_cnt++;
      if (wr_bus) begin
        wr_cnt++;
        wdata_seen = data_bus;
      end
      if (rd_bus || wr_bus) begin
        mask_seen = data_mask_bus;
        addr_seen = addr_bus;
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] bus;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    int          lat;
  } vec_t;

  vec_t vt[10];

  int          lat, rd_cnt, wr_cnt;
  logic [3:0]  mask_seen;
  logic [31:0] addr_seen, wdata_seen;
  int          seen_resp;

  initial begin
    n_tests = 0; n_fail = 0;
    mode = 0; rsp_data = '0; force_drv = 1'b0; force_val = '0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0;
    rst = 1'b1;

    //            we    addr          wdata         sz    uns   bus data      err   rdata         mask     lat
    vt[0] = '{1'b0, 32'h1000_0008, 32'h0,         2'd2, 1'b0, 32'h8000_0001, 1'b0, 32'h8000_0001, 4'b1111, 3};
    vt[1] = '{1'b0, 32'h1000_0003, 32'h0,         2'd0, 1'b0, 32'h0000_00F0, 1'b0, 32'hFFFF_FFF0, 4'b0001, 3};
    vt[2] = '{1'b0, 32'h1000_0003, 32'h0,         2'd0, 1'b1, 32'h0000_00F0, 1'b0, 32'h0000_00F0, 4'b0001, 3};
    vt[3] = '{1'b0, 32'h1000_0002, 32'h0,         2'd1, 1'b0, 32'h1234_8001, 1'b0, 32'hFFFF_8001, 4'b0011, 3};
    vt[4] = '{1'b0, 32'h1000_0000, 32'h0,         2'd1, 1'b1, 32'hFFFF_7FFE, 1'b0, 32'h0000_7FFE, 4'b0011, 3};
    vt[5] = '{1'b0, 32'h1000_0001, 32'h0,         2'd0, 1'b0, 32'h1234_567F, 1'b0, 32'h0000_007F, 4'b0001, 3};
    vt[6] = '{1'b0, 32'h1000_0006, 32'h0,         2'd2, 1'b0, 32'h0,         1'b1, 32'h0,         4'b0000, 1};
    vt[7] = '{1'b0, 32'h1000_0000, 32'h0,         2'd3, 1'b0, 32'h0,         1'b1, 32'h0,         4'b0000, 1};
    vt[8] = '{1'b1, 32'h1000_0001, 32'h1111_2222, 2'd1, 1'b0, 32'h0,         1'b1, 32'h0,         4'b0000, 1};
    vt[9] = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,         1'b0, 32'h0,         4'b1111, 3};

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_addr_bus", addr_bus, 32'd0);
    check("rst_strobes", {30'd0, rd_bus, wr_bus}, 32'd0);
    check("rst_mask", 32'(data_mask_bus), 32'd0);
    rst = 1'b0;
    cyc();

    mode = 1;
    for (int i = 0; i < 10; i++) begin
      run_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns, vt[i].bus,
              lat, rd_cnt, wr_cnt, mask_seen, addr_seen, wdata_seen);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("v%0d_err", i), 32'(resp_err), 32'(vt[i].err));
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
      if (vt[i].err) begin
        check($sformatf("v%0d_rdata", i), resp_rdata, 32'd0);
        check($sformatf("v%0d_strobes", i), 32'(rd_cnt + wr_cnt), 32'd0);
      end else begin
        check($sformatf("v%0d_mask", i), 32'(mask_seen), 32'(vt[i].mask));
        check($sformatf("v%0d_addr", i), addr_seen, vt[i].addr);
        check($sformatf("v%0d_rd_cycles", i), 32'(rd_cnt), vt[i].we ? 32'd0 : 32'd1);
        check($sformatf("v%0d_wr_cycles", i), 32'(wr_cnt), vt[i].we ? 32'd1 : 32'd0);
        if (vt[i].we) check($sformatf("v%0d_wdata", i), wdata_seen, vt[i].wdata);
        else          check($sformatf("v%0d_rdata", i), resp_rdata, vt[i].rdata);
      end
    end

    // Half write against a responder whose fc lags the strobe by one cycle.
    mode = 2;
    run_txn(1'b1, 32'h1000_0002, 32'h0000_ABCD, 2'd1, 1'b0, 32'h0,
            lat, rd_cnt, wr_cnt, mask_seen, addr_seen, wdata_seen);
    check("hw_latency", 32'(lat), 32'd5);
    check("hw_wr_cycles", 32'(wr_cnt), 32'd2);
    check("hw_rd_cycles", 32'(rd_cnt), 32'd0);
    check("hw_wdata", wdata_seen, 32'h0000_ABCD);
    check("hw_mask", 32'(mask_seen), 32'b0011);
    check("hw_err", 32'(resp_err), 32'd0);
    force_drv = 1'b1; force_val = 32'h5A5A_5A5A;
    #1;
    check("hw_bus_released", data_bus, 32'h5A5A_5A5A);
    force_drv = 1'b0;
    cyc();

    // Nobody answers: four ACCESS cycles, then an error response.
    mode = 0;
    run_txn(1'b0, 32'h2000_0000, 32'h0, 2'd2, 1'b0, 32'h0,
            lat, rd_cnt, wr_cnt, mask_seen, addr_seen, wdata_seen);
    check("to_rd_cycles", 32'(rd_cnt), 32'd4);
    check("to_latency", 32'(lat), 32'd6);
    check("to_err", 32'(resp_err), 32'd1);
    check("to_rdata", resp_rdata, 32'd0);
    check("to_ready", 32'(req_ready), 32'd1);
    cyc();
    check("to_resp_pulse", 32'(resp_valid), 32'd0);

    // Reset in the middle of a write ACCESS.
    mode = 0;
    req_we = 1'b1; req_addr = 32'h1000_0020; req_wdata = 32'hCAFE_F00D;
    req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    cyc();
    check("mr_wr_before", 32'(wr_bus), 32'd1);
    check("mr_ready_before", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mr_wr_after", 32'(wr_bus), 32'd0);
    check("mr_ready_after", 32'(req_ready), 32'd1);
    force_drv = 1'b1; force_val = 32'h0F0F_1234;
    #1;
    check("mr_bus_released", data_bus, 32'h0F0F_1234);
    force_drv = 1'b0;
    cyc();
    rst = 1'b0;
    seen_resp = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (resp_valid || wr_bus || rd_bus) seen_resp++;
    end
    check("mr_no_resp", 32'(seen_resp), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
